// File: rtl/de_scoreboard_pkg.sv
// Shared constants, types and helpers for the decode-stage register scoreboard.
// Build option: define DE_SB_WB_BYPASS_EN to let a same-cycle WB retire relieve stalls.
package de_scoreboard_pkg;

  localparam int REGNOBITS = 5;

`ifdef DE_SB_WB_BYPASS_EN
  localparam bit WB_BYPASS_EN = 1'b1;
`else
  localparam bit WB_BYPASS_EN = 1'b0;
`endif

  // from_WB_to_DE field layout
  typedef struct packed {
    logic                 wb_valid;
    logic [REGNOBITS-1:0] wb_regno;
  } wb_to_de_t;

  // Modulo add for queue pointers; the queue depth need not be a power of two.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned m);
    return (a + b) % m;
  endfunction

endpackage

// File: rtl/de_sb_queue.sv
// In-order circular FIFO of destination register IDs with head pop and multi-entry
// tail squash; exposes the squashed slots as a mask plus the raw entry array.
module de_sb_queue
  import de_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REGNO_BITS = REGNOBITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [REGNO_BITS-1:0]         push_rd_i,
  input  logic                          pop_i,
  input  logic [$clog2(DEPTH+1)-1:0]    squash_n_i,
  output logic [REGNO_BITS-1:0]         head_rd_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o,
  output logic [DEPTH-1:0]              squash_mask_o,
  output logic [REGNO_BITS-1:0]         entry_rd_o [DEPTH]
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REGNO_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, avail, nsq;
  logic          push_w;

  // Squash only reaches entries that survive this cycle's pop.
  assign avail  = count_q - CW'(pop_i);
  assign nsq    = (squash_n_i < avail) ? squash_n_i : avail;
  // A push never lands in the same cycle as a squash.
  assign push_w = push_i && (squash_n_i == '0);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    assign squash_mask_o[gi] =
      wrap_add(32'(tail_q), unsigned'(DEPTH - 1 - gi), DEPTH) < 32'(nsq);
  end

  always_comb begin
    head_d  = pop_i ? PW'(wrap_add(32'(head_q), 1, DEPTH)) : head_q;
    tail_d  = tail_q;
    if (nsq != '0)
      tail_d = PW'(wrap_add(32'(tail_q), unsigned'(DEPTH) - 32'(nsq), DEPTH));
    else if (push_w)
      tail_d = PW'(wrap_add(32'(tail_q), 1, DEPTH));
    count_d = count_q + CW'(push_w) - CW'(pop_i) - nsq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[tail_q] <= push_rd_i;
  end

  assign entry_rd_o = mem_q;
  assign head_rd_o  = mem_q[head_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage register hazard scoreboard: per-register pending-write counters fed by
// an in-order in-flight queue; drives the DE->FE stall and a sticky WB ordering error.
module de_scoreboard
  import de_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REGNO_BITS = REGNOBITS,
  parameter int DEPTH      = 4,
  parameter int NUM_SRC    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic                           issue_wr_reg,
  input  logic [REGNO_BITS-1:0]          issue_rd,
  input  logic [NUM_SRC-1:0]             src_read,
  input  logic [NUM_SRC*REGNO_BITS-1:0]  src_regno,
  input  logic                           wb_valid,
  input  logic [REGNO_BITS-1:0]          wb_regno,
  input  logic                           flush_valid,
  input  logic [$clog2(DEPTH+1)-1:0]     flush_count,
  output logic                           stall,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           wb_mismatch
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NR = 2**REGNO_BITS;

  logic [REGNO_BITS-1:0] head_rd;
  logic [CW-1:0]         count;
  logic                  full;
  logic [DEPTH-1:0]      sq_mask;
  logic [REGNO_BITS-1:0] sq_rd [DEPTH];
  logic [CW-1:0]         pend [NR];
  logic [NUM_SRC-1:0]    src_haz;
  logic                  retire, accept, hazard, full_stall;
  logic                  mismatch_q, mismatch_d;

  assign retire = wb_valid && (count != '0);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REGNO_BITS-1:0] rn;
    logic [CW-1:0]         p;
    assign rn = src_regno[gi*REGNO_BITS +: REGNO_BITS];
    assign p  = pend[rn];
    // The last outstanding writer retiring now is written on the negedge, so no hazard.
    assign src_haz[gi] = src_read[gi] && (rn != '0) && (p != '0) &&
                         !(WB_BYPASS_EN && wb_valid && (wb_regno == rn) && (p == CW'(1)));
  end

  assign hazard     = |src_haz;
  assign full_stall = full && issue_valid && issue_wr_reg && (issue_rd != '0) &&
                      !(WB_BYPASS_EN && retire);
  assign stall      = hazard || full_stall;
  assign accept     = issue_valid && !stall && !flush_valid && issue_wr_reg && (issue_rd != '0);

  de_sb_queue #(
    .DEPTH      (DEPTH),
    .REGNO_BITS (REGNO_BITS)
  ) u_queue (
    .clk           (clk),
    .reset         (reset),
    .push_i        (accept),
    .push_rd_i     (issue_rd),
    .pop_i         (retire),
    .squash_n_i    (flush_valid ? flush_count : '0),
    .head_rd_o     (head_rd),
    .count_o       (count),
    .full_o        (full),
    .squash_mask_o (sq_mask),
    .entry_rd_o    (sq_rd)
  );

  for (genvar gi = 0; gi < NR; gi++) begin : g_pend
    if (gi == 0 || gi >= NUM_REGS) begin : g_untracked
      assign pend[gi] = '0;
    end else begin : g_cnt
      logic [CW-1:0] cnt_q, cnt_d, dec_sq;
      logic          inc, ret;
      assign inc = accept && (issue_rd == REGNO_BITS'(gi));
      assign ret = retire && (head_rd == REGNO_BITS'(gi));
      // Several squashed entries may name this register.
      always_comb begin
        dec_sq = '0;
        for (int s = 0; s < DEPTH; s++)
          if (sq_mask[s] && (sq_rd[s] == REGNO_BITS'(gi))) dec_sq = dec_sq + CW'(1);
        cnt_d = cnt_q + CW'(inc) - CW'(ret) - dec_sq;
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
      assign pend[gi] = cnt_q;
    end
  end

  assign mismatch_d = mismatch_q || (wb_valid && ((count == '0) || (wb_regno != head_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mismatch_q <= 1'b0;
    else       mismatch_q <= mismatch_d;
  end

  assign occupancy   = count;
  assign wb_mismatch = mismatch_q;

endmodule

// File: tb/tb_de_scoreboard.sv
// Bench for de_scoreboard: directed vector table followed by random traffic checked
// against a queue-based reference model.
module tb_de_scoreboard;
  localparam int RB = 5, DEPTH = 4, NS = 2, CW = 3;
`ifdef DE_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b0;
  logic          issue_valid = 0, issue_wr_reg = 0, wb_valid = 0, flush_valid = 0;
  logic [RB-1:0] issue_rd = '0, wb_regno = '0;
  logic [NS-1:0] src_read = '0;
  logic [NS*RB-1:0] src_regno = '0;
  logic [CW-1:0] flush_count = '0;
  logic          stall, wb_mismatch;
  logic [CW-1:0] occupancy;

  always #5 clk = ~clk;

  de_scoreboard #(.NUM_REGS(32), .REGNO_BITS(RB), .DEPTH(DEPTH), .NUM_SRC(NS)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg),
    .issue_rd(issue_rd), .src_read(src_read), .src_regno(src_regno), .wb_valid(wb_valid),
    .wb_regno(wb_regno), .flush_valid(flush_valid), .flush_count(flush_count),
    .stall(stall), .occupancy(occupancy), .wb_mismatch(wb_mismatch)
  );

  typedef struct {
    bit rst; bit iv; bit iwr; int rd; bit [1:0] srd; int s0; int s1;
    bit wbv; int wbr; bit fv; int fc; bit e_stall; int e_occ; bit e_mism;
  } vec_t;

  int checks = 0, errors = 0;
  int mq[$];
  bit mmism = 0;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit iv, bit iwr, int rd, bit [1:0] srd, int s0, int s1,
                              bit wbv, int wbr, bit fv, int fc, bit es, int eo, bit em);
    vec_t v;
    v.rst = rst; v.iv = iv; v.iwr = iwr; v.rd = rd; v.srd = srd; v.s0 = s0; v.s1 = s1;
    v.wbv = wbv; v.wbr = wbr; v.fv = fv; v.fc = fc; v.e_stall = es; v.e_occ = eo; v.e_mism = em;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit iv, bit iwr, int rd, bit [1:0] srd, int s0, int s1,
                       bit wbv, int wbr, bit fv, int fc);
    issue_valid = iv; issue_wr_reg = iwr; issue_rd = RB'(rd);
    src_read = srd; src_regno = {RB'(s1), RB'(s0)};
    wb_valid = wbv; wb_regno = RB'(wbr); flush_valid = fv; flush_count = CW'(fc);
  endtask

  // Asynchronous reset in the low clock phase, with inputs that would stall on stale state.
  task automatic do_reset();
    @(negedge clk);
    drive(1, 1, 9, 2'b11, 3, 5, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_wb_mismatch", wb_mismatch, 0);
    #1 reset = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    mq.delete();
    mmism = 0;
    $display("reset applied");
  endtask

  function automatic int mpend(int r);
    int n = 0;
    foreach (mq[k]) if (mq[k] == r) n++;
    return n;
  endfunction

  function automatic bit mstall();
    bit h = 0;
    int r[2];
    r[0] = int'(src_regno[RB-1:0]);
    r[1] = int'(src_regno[2*RB-1:RB]);
    for (int i = 0; i < NS; i++)
      if (src_read[i] && r[i] != 0 && mpend(r[i]) != 0 &&
          !(BYP && wb_valid && int'(wb_regno) == r[i] && mpend(r[i]) == 1)) h = 1;
    return h || (mq.size() == DEPTH && issue_valid && issue_wr_reg && issue_rd != 0 &&
                 !(BYP && wb_valid));
  endfunction

  task automatic mstep(bit st);
    if (wb_valid) begin
      if (mq.size() == 0) mmism = 1;
      else begin
        if (mq[0] != int'(wb_regno)) mmism = 1;
        void'(mq.pop_front());
      end
    end
    if (flush_valid) begin
      int n;
      n = (int'(flush_count) < mq.size()) ? int'(flush_count) : mq.size();
      repeat (n) void'(mq.pop_back());
    end else if (issue_valid && !st && issue_wr_reg && issue_rd != 0) begin
      mq.push_back(int'(issue_rd));
    end
  endtask

  initial begin
    //            rst iv iwr rd srd   s0 s1 wbv wbr fv fc  stall  occ          mism
    tbl.push_back(mk(0, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0,     1,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 1,     1,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 5, 0, 1, 5, 0, 0, !BYP,  0,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 0,     0,           0));
    tbl.push_back(mk(0, 1, 1, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0,     1,           0));
    tbl.push_back(mk(0, 1, 1, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0,     2,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 7, 0, 1, 7, 0, 0, 1,     1,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 7, 0, 1, 7, 0, 0, !BYP,  0,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 7, 0, 0, 0, 0, 0, 0,     0,           0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0,     0,           0));
    for (int r = 1; r <= 4; r++)
      tbl.push_back(mk(0, 1, 1, r, 2'b00, 0, 0, 0, 0, 0, 0, 0,   r,           0));
    tbl.push_back(mk(0, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0, 0, 1,     4,           0));
    tbl.push_back(mk(0, 1, 1, 5, 2'b00, 0, 0, 1, 1, 0, 0, !BYP,  BYP ? 4 : 3, 0));
    tbl.push_back(mk(1, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0,     1,           0));
    tbl.push_back(mk(0, 1, 1, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0,     2,           0));
    tbl.push_back(mk(0, 1, 1, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0,     3,           0));
    tbl.push_back(mk(0, 1, 1, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0,     4,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 1, 2, 0,     1,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 3, 2, 0, 0, 0, 0, 0,     1,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b10, 3, 2, 0, 0, 0, 0, 1,     1,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 9, 0, 0, 0,     0,           1));
    tbl.push_back(mk(0, 1, 1, 6, 2'b00, 0, 0, 0, 0, 1, 0, 0,     0,           1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,     0,           0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 4, 0, 0, 0,     0,           1));

    do_reset();
    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      if (v.rst) do_reset();
      @(negedge clk);
      drive(v.iv, v.iwr, v.rd, v.srd, v.s0, v.s1, v.wbv, v.wbr, v.fv, v.fc);
      #1;
      chk($sformatf("row%0d_stall", i), stall, v.e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_occupancy", i), occupancy, v.e_occ);
      chk($sformatf("row%0d_wb_mismatch", i), wb_mismatch, v.e_mism);
      $display("row %0d: stall=%0d occupancy=%0d wb_mismatch=%0d", i, stall, occupancy, wb_mismatch);
    end

    do_reset();
    for (int c = 0; c < 500; c++) begin
      bit st;
      bit wbv;
      int wbr;
      if ($urandom_range(0, 99) == 0) do_reset();
      @(negedge clk);
      wbv = (mq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3);
      wbr = int'($urandom_range(0, 7));
      if (mq.size() > 0 && $urandom_range(0, 19) != 0) wbr = mq[0];
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            wbv, wbr, $urandom_range(0, 11) == 0, int'($urandom_range(0, 4)));
      #1;
      st = mstall();
      chk("rnd_stall", stall, st);
      @(posedge clk);
      mstep(st);
      #1;
      chk("rnd_occupancy", occupancy, mq.size());
      chk("rnd_wb_mismatch", wb_mismatch, mmism);
      $display("rnd %0d: stall=%0d occupancy=%0d wb_mismatch=%0d", c, stall, occupancy, wb_mismatch);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/de_scoreboard.md
# de_scoreboard

Parametrised register-hazard scoreboard for the decode stage. It replaces the per-stage destination-register comparison with per-register pending-write counters and an in-order in-flight queue. Decode stalls while any source register has an outstanding write, and a branch redirect squashes the youngest queued writers. It sits between the FE latch decode logic and the DE latch and drives the DE→FE stall bit.

## Interface
Parameters:
- `NUM_REGS`, 32 — architectural registers tracked; register 0 is never tracked.
- `REGNO_BITS`, 5 — register ID width; `NUM_REGS <= 2**REGNO_BITS`.
- `DEPTH`, 4 — in-flight queue entries, one per writing instruction between DE and WB.
- `NUM_SRC`, 2 — source operands checked per instruction.

Ports:
- `clk`  in  1 — clock.
- `reset`  in  1 — asynchronous, active-high.
- `issue_valid`  in  1 — decode wants to latch an instruction into DE this cycle.
- `issue_wr_reg`  in  1 — the issuing instruction writes a register.
- `issue_rd`  in  `REGNO_BITS` — destination register ID.
- `src_read`  in  `NUM_SRC` — per-source read enable.
- `src_regno`  in  `NUM_SRC*REGNO_BITS` — source IDs, with source i at bits [i*REGNO_BITS +: REGNO_BITS].
- `wb_valid`  in  1 — WB retires a register-writing instruction.
- `wb_regno`  in  `REGNO_BITS` — register ID written by WB.
- `flush_valid`  in  1 — branch redirect from AGEX.
- `flush_count`  in  $clog2(`DEPTH`+1) — number of youngest queue entries to squash.
- `stall`  out  1 — hazard or queue full; feeds DE→FE.
- `occupancy`  out  $clog2(`DEPTH`+1) — number of valid queue entries.
- `wb_mismatch`  out  1 — sticky error flag.

## Operation
- State:
  - Per-register counter `pend[r]`, width $clog2(`DEPTH`+1).
  - Circular queue of `DEPTH` rd IDs with head/tail pointers and a count.
- `hazard` = OR over sources i of (`src_read[i]` & `src_regno[i]` != 0 & `pend[src_regno[i]]` != 0), minus bypass (see Configuration).
- `stall` = `hazard` | (queue full & `issue_valid` & `issue_wr_reg` & `issue_rd` != 0 & !retire_this_cycle).
- Issue accepted = `issue_valid` & !`stall` & !`flush_valid` & `issue_wr_reg` & `issue_rd` != 0. On accept: push `issue_rd` at the tail and increment `pend[issue_rd]`.
- Retire: when `wb_valid` and the queue is non-empty, pop the head and decrement `pend[head_rd]`.
  - If `wb_regno` != head_rd, set `wb_mismatch`. It stays set until reset.
  - `wb_valid` on an empty queue is ignored and sets `wb_mismatch`.
- Flush: remove min(`flush_count`, occupancy after retire) entries from the tail and decrement each removed entry's counter. Multiple entries may hit the same register, so the net decrement per register equals its number of removed entries.
- Simultaneous events, resolved in the same cycle:
  - Retire and issue to the same register: counter net unchanged.
  - Retire and flush: retire takes the oldest entry, flush takes the youngest.
  - Flush and issue: the issue is dropped. Decode kills that instruction.
- Counters cannot overflow: the sum of all `pend` equals occupancy, which is at most `DEPTH`.
- Wrap-around: pointers are modulo `DEPTH`. `DEPTH` need not be a power of two.

## Timing
- `stall` is combinational from `src_*`, `issue_*`, `wb_*` and registered state. There is no clocked path from `src_regno` to `stall`.
- All state updates on posedge `clk`. A push is visible to `stall` on the next cycle.
- Register file writes happen on the negedge in the decode stage. A register retired in cycle N is readable in cycle N with bypass, and in cycle N+1 without.
- Reset (asynchronous, mid-operation included):
  - All `pend` = 0, pointers = 0, `occupancy` = 0, `wb_mismatch` = 0.
  - `stall` = 0 once reset is applied.

## Configuration
- `DE_SB_WB_BYPASS_EN` defined:
  - A source does not hazard if `wb_valid` & `wb_regno` == source & `pend[source]` == 1, since the same-cycle negedge write makes the value available.
  - The full-queue stall is also relieved by a same-cycle retire.
- Not defined:
  - Any `pend` != 0 hazards.
  - A full queue stalls regardless of retire.

## Structure
- Shared package / `VX_define.vh`: `REGNOBITS`, the `DE_SB_WB_BYPASS_EN` default, and the from_WB_to_DE field layout carrying `wb_valid`/`wb_regno`.
- Sub-module `de_sb_queue`: a circular rd FIFO with push, pop, and multi-entry tail squash. It outputs the squashed IDs as a `DEPTH`-wide valid mask plus an entry array for counter decrement.
- Counters, hazard compare and stall logic live in the top module.

## Test plan
- Reset, then issue `rd`=5. The next cycle, sources (5,0) → `stall`=1. After WB retires 5 → `stall`=0 (same cycle with bypass, next cycle without). `occupancy` goes 0→1→0.
- Issue `rd`=7 twice, retire once → `pend[7]`=1. A read of 7 still stalls. The second retire clears it.
- Sources (0,0) with `src_read`=11 after issuing `rd`=0 → no stall, and `occupancy` stays 0.
- Fill `DEPTH`=4 with rd 1,2,3,4; a fifth writer → `stall`=1. With bypass and a same-cycle retire, the fifth is accepted and `occupancy` stays 4.
- Queue 1,2,3,3, then `flush_count`=2 with a simultaneous retire → entry 1 popped, two 3s squashed. `pend[3]`=0, `pend[2]`=1, `occupancy`=1.
- Retire with `wb_regno`=9 while head=2 → `wb_mismatch`=1, sticky until `reset` pulses mid-run. After reset, all outputs are 0.
